// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - in-order ROB retire stage: retire, drain store, or flush on mispredict.
// Optional RVFI retirement trace is enabled with `define ROB_COMMIT_RVFI_EN.
package rob_pkg;
  localparam int ROB_IDX_W = 4;
  typedef enum logic [1:0] {rob_wait = 2'd0, done = 2'd1, rob_exc = 2'd2} rob_status_t;
  typedef enum logic [1:0] {op_alu = 2'd0, op_br = 2'd1, op_ld = 2'd2, op_st = 2'd3} op_type_t;
  typedef struct packed {
    logic                 valid;
    rob_status_t          status;
    op_type_t             op_type;
    logic [31:0]          pc;
    logic [31:0]          pc_new;
    logic [31:0]          insn;
    logic                 br_en;
    logic                 prediction;
    logic                 regf_we;
    logic [4:0]           rd_addr;
    logic [31:0]          rd_data;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic [3:0]           mem_wmask;
  } rob_entry_t;
endpackage

module rob_commit
  import rob_pkg::*;
#(
  parameter int ROB_DEPTH    = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  rob_entry_t                   rob_head_i,
  output logic                         dequeue_o,
  output logic                         flush_o,
  output logic [31:0]                  pc_redirect_o,
  output logic                         regf_we_o,
  output logic [4:0]                   rd_addr_o,
  output logic [31:0]                  rd_data_o,
  output logic [$clog2(ROB_DEPTH)-1:0] rd_rob_idx_o,
  output logic                         store_req_o,
  output logic [31:0]                  store_addr_o,
  output logic [31:0]                  store_wdata_o,
  output logic [3:0]                   store_wmask_o,
  input  logic                         store_ack_i,
`ifdef ROB_COMMIT_RVFI_EN
  output logic                         rvfi_valid,
  output logic [63:0]                  rvfi_order,
  output logic [31:0]                  rvfi_pc_rdata,
  output logic [31:0]                  rvfi_pc_wdata,
  output logic [31:0]                  rvfi_insn,
  output logic [4:0]                   rvfi_rd_addr,
  output logic [31:0]                  rvfi_rd_wdata,
  output logic [31:0]                  rvfi_mem_addr,
  output logic [31:0]                  rvfi_mem_wdata,
  output logic [3:0]                   rvfi_mem_wmask,
`endif
  output logic                         commit_busy_o
);
  localparam int IDX_W = $clog2(ROB_DEPTH);

  typedef enum logic [1:0] {RUN = 2'd0, STORE_WAIT = 2'd1, FLUSH = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [3:0]  flush_cnt;
  logic        head_ready, is_store, is_misp, retire, rd_wr;
  logic [31:0] next_pc;

  assign head_ready = rob_head_i.valid && (rob_head_i.status == done);
  assign is_store   = head_ready && (rob_head_i.mem_wmask != 4'd0);
  assign is_misp    = head_ready && (rob_head_i.op_type == op_br) &&
                      (rob_head_i.br_en != rob_head_i.prediction);
  assign next_pc    = (rob_head_i.op_type == op_br && rob_head_i.br_en) ?
                      rob_head_i.pc_new : rob_head_i.pc + 32'd4;
  assign rd_wr      = rob_head_i.regf_we && (rob_head_i.rd_addr != 5'd0);
  // A flushing branch still retires: its link register is written like any other.
  assign retire     = dequeue_o || flush_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state == RUN && is_misp)
        flush_cnt <= 4'(FLUSH_CYCLES);
      else if (state == FLUSH)
        flush_cnt <= flush_cnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (is_store)
          state_nxt = STORE_WAIT;
        else if (is_misp)
          state_nxt = FLUSH;
      end
      STORE_WAIT: if (store_ack_i) state_nxt = RUN;
      FLUSH:      if (flush_cnt <= 4'd1) state_nxt = RUN;
      default:    state_nxt = RUN;
    endcase
  end

  // Gated by rst so nothing retires while reset is held with a ready head.
  always_comb begin
    dequeue_o     = 1'b0;
    flush_o       = 1'b0;
    pc_redirect_o = 32'd0;
    if (!rst) begin
      case (state)
        RUN: begin
          dequeue_o = head_ready && !is_store && !is_misp;
          flush_o   = is_misp;
          if (is_misp)
            pc_redirect_o = next_pc;
        end
        STORE_WAIT: dequeue_o = store_ack_i;
        default: ;
      endcase
    end
  end

  assign commit_busy_o = (state != RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regf_we_o     <= 1'b0;
      rd_addr_o     <= 5'd0;
      rd_data_o     <= 32'd0;
      rd_rob_idx_o  <= '0;
      store_req_o   <= 1'b0;
      store_addr_o  <= 32'd0;
      store_wdata_o <= 32'd0;
      store_wmask_o <= 4'd0;
    end else begin
      regf_we_o <= 1'b0;
      if (retire) begin
        regf_we_o    <= rd_wr;
        rd_addr_o    <= rob_head_i.rd_addr;
        rd_data_o    <= rob_head_i.rd_data;
        rd_rob_idx_o <= IDX_W'(rob_head_i.rob_idx);
      end
      if (state == RUN && is_store) begin
        store_req_o   <= 1'b1;
        store_addr_o  <= rob_head_i.mem_addr;
        store_wdata_o <= rob_head_i.mem_wdata;
        store_wmask_o <= rob_head_i.mem_wmask;
      end else if (state == STORE_WAIT && store_ack_i) begin
        store_req_o <= 1'b0;
      end
    end
  end

`ifdef ROB_COMMIT_RVFI_EN
  logic [63:0] order_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      order_cnt      <= 64'd0;
      rvfi_valid     <= 1'b0;
      rvfi_order     <= 64'd0;
      rvfi_pc_rdata  <= 32'd0;
      rvfi_pc_wdata  <= 32'd0;
      rvfi_insn      <= 32'd0;
      rvfi_rd_addr   <= 5'd0;
      rvfi_rd_wdata  <= 32'd0;
      rvfi_mem_addr  <= 32'd0;
      rvfi_mem_wdata <= 32'd0;
      rvfi_mem_wmask <= 4'd0;
    end else begin
      rvfi_valid <= retire;
      if (retire) begin
        order_cnt      <= order_cnt + 64'd1;
        rvfi_order     <= order_cnt;
        rvfi_pc_rdata  <= rob_head_i.pc;
        rvfi_pc_wdata  <= next_pc;
        rvfi_insn      <= rob_head_i.insn;
        rvfi_rd_addr   <= rd_wr ? rob_head_i.rd_addr : 5'd0;
        rvfi_rd_wdata  <= rd_wr ? rob_head_i.rd_data : 32'd0;
        rvfi_mem_addr  <= rob_head_i.mem_addr;
        rvfi_mem_wdata <= rob_head_i.mem_wdata;
        rvfi_mem_wmask <= rob_head_i.mem_wmask;
      end
    end
  end
`else
  logic unused_insn;
  assign unused_insn = ^rob_head_i.insn;
`endif
endmodule
